sha256_iter_core: RTL

Iterative, parametrised SHA-256 compression engine. It accepts a 256-bit chaining state and a 512-bit message block, and runs the 64 rounds at ROUNDS_PER_CYCLE rounds per clock. It then applies the feed-forward addition and presents the 256-bit digest with a one-cycle valid strobe. It sits between the work-distribution logic and the nonce checker, and lets the team trade area against throughput without touching the datapath. It is built from the shared SHA-256 function primitives (e0, e1, ch, maj, s0, s1) plus an internal K-constant ROM and message-schedule window.

---
 rtl/sha256_iter_core.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sha256_iter_core.sv
// sha256_iter_core: iterative SHA-256 compression, ROUNDS_PER_CYCLE rounds per clock.
module sha256_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] state_in,
  input  logic [511:0] data_in,
  output logic         ready,
  output logic         busy,
  output logic         digest_valid,
  output logic [255:0] digest
);
  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FINAL = 2'd2;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_r
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] e0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] e1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  logic [1:0]   st_q, st_d;
  logic [31:0]  hreg_q [8], hreg_d [8];
  logic [31:0]  v_q [8], v_d [8];
  logic [31:0]  w_q [16], w_d [16];
  logic [5:0]   rnd_q, rnd_d;
  logic [255:0] digest_q, digest_d;
  logic         valid_q, valid_d;
  logic [31:0]  ext [16+R];
  logic [31:0]  v [8];
  logic [31:0]  t1, t2;

  always_comb begin
    st_d = st_q;
    hreg_d = hreg_q;
    v_d = v_q;
    w_d = w_q;
    rnd_d = rnd_q;
    digest_d = digest_q;
    valid_d = 1'b0;
    t1 = '0;
    t2 = '0;
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    // ext[16+j] may use ext[14+j], so later words chain off earlier new ones
    for (int j = 0; j < R; j++) ext[16+j] = s1(ext[14+j]) + ext[9+j] + s0(ext[1+j]) + ext[j];
    v = v_q;
    for (int j = 0; j < R; j++) begin
      t1 = v[7] + e1(v[4]) + ch(v[4], v[5], v[6]) + K[rnd_q + 6'(j)] + ext[j];
      t2 = e0(v[0]) + maj(v[0], v[1], v[2]);
      v[7] = v[6];
      v[6] = v[5];
      v[5] = v[4];
      v[4] = v[3] + t1;
      v[3] = v[2];
      v[2] = v[1];
      v[1] = v[0];
      v[0] = t1 + t2;
    end
    if (st_q == IDLE && start) begin
      st_d = RUN;
      rnd_d = '0;
      for (int i = 0; i < 8; i++) hreg_d[i] = state_in[255-32*i -: 32];
      for (int i = 0; i < 8; i++) v_d[i] = state_in[255-32*i -: 32];
      for (int i = 0; i < 16; i++) w_d[i] = data_in[511-32*i -: 32];
    end else if (st_q == RUN) begin
      v_d = v;
      for (int i = 0; i < 16; i++) w_d[i] = ext[R+i];
      rnd_d = rnd_q + 6'(R);
      st_d = (rnd_q == 6'(64 - R)) ? FINAL : RUN;
    end else if (st_q == FINAL) begin
      for (int i = 0; i < 8; i++) digest_d[255-32*i -: 32] = hreg_q[i] + v_q[i];
      valid_d = 1'b1;
      st_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      hreg_q <= '{default: '0};
      v_q <= '{default: '0};
      w_q <= '{default: '0};
      rnd_q <= '0;
      digest_q <= '0;
      valid_q <= 1'b0;
    end else begin
      st_q <= st_d;
      hreg_q <= hreg_d;
      v_q <= v_d;
      w_q <= w_d;
      rnd_q <= rnd_d;
      digest_q <= digest_d;
      valid_q <= valid_d;
    end
  end

  assign ready = (st_q == IDLE);
  assign busy = !ready;
  assign digest_valid = valid_q;
  assign digest = digest_q;
endmodule
